// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared constants, id types and channel payloads for the xadac vector path
package xadac_pkg;

  localparam int NoVec   = 32;
  localparam int VecBits = 256;
  localparam int NoVs    = 3;
  localparam int IdBits  = 4;

  typedef logic [$clog2(NoVec)-1:0] RegIdT;
  typedef logic [IdBits-1:0]        IdT;
  typedef logic [VecBits-1:0]       VecT;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
  } dec_req_t;

  typedef struct packed {
    IdT              id;
    logic [NoVs-1:0] vs_read;
    logic            vd_write;
  } dec_rsp_t;

  typedef struct packed {
    IdT                             id;
    logic [31:0]                    instr;
    logic [NoVs-1:0][VecBits-1:0]   vs_data;
  } exe_req_t;

  typedef struct packed {
    IdT    id;
    logic  vd_write;
    RegIdT vd_id;
    VecT   vd_data;
  } exe_rsp_t;

  // Source operand register fields: vs1, vs2, then the vd field reused as a third source.
  function automatic RegIdT vs_id(input logic [31:0] instr, input logic [1:0] idx);
    case (idx)
      2'd0:    return instr[19:15];
      2'd1:    return instr[24:20];
      default: return instr[11:7];
    endcase
  endfunction

endpackage

// File: rtl/xadac_if.sv
// rtl/xadac_if.sv - decode/execute request-response channels between xadac pipeline stages
interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;
  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport mst (
    output dec_req_valid, dec_req, input  dec_req_ready,
    input  dec_rsp_valid, dec_rsp, output dec_rsp_ready,
    output exe_req_valid, exe_req, input  exe_req_ready,
    input  exe_rsp_valid, exe_rsp, output exe_rsp_ready
  );

  modport slv (
    input  dec_req_valid, dec_req, output dec_req_ready,
    output dec_rsp_valid, dec_rsp, input  dec_rsp_ready,
    input  exe_req_valid, exe_req, output exe_req_ready,
    output exe_rsp_valid, exe_rsp, input  exe_rsp_ready
  );

endinterface

// File: rtl/xadac_vregfile_mem.sv
// rtl/xadac_vregfile_mem.sv - vector register array, one combinational read port, one write port
module xadac_vregfile_mem #(
  parameter int   NoVec    = xadac_pkg::NoVec,
  parameter int   VecBits  = xadac_pkg::VecBits,
  localparam int  AddrBits = $clog2(NoVec)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [VecBits-1:0]  wdata_i,
  input  logic [AddrBits-1:0] raddr_i,
  output logic [VecBits-1:0]  rdata_o
);

  logic [VecBits-1:0] mem_q [NoVec];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NoVec; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read colliding with this cycle's write sees the incoming data.
  assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/xadac_vregfile.sv
// rtl/xadac_vregfile.sv - gathers three source vectors per execute request, retires results into the VRF
module xadac_vregfile
  import xadac_pkg::*;
#(
  parameter int NoVec   = xadac_pkg::NoVec,
  parameter int VecBits = xadac_pkg::VecBits,
  parameter int NoVs    = xadac_pkg::NoVs
) (
  input logic   clk,
  input logic   rstn,
  xadac_if.slv  slv,
  xadac_if.mst  mst
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, SEND} state_e;

  state_e                    state_q, state_d;
  exe_req_t                  req_q;
  logic                      rd_en;
  logic [$clog2(NoVs)-1:0]   rd_sel;
  RegIdT                     rd_addr;
  VecT                       rd_data;
  logic                      wr_en;

  assign mst.dec_req_valid = slv.dec_req_valid;
  assign mst.dec_req       = slv.dec_req;
  assign slv.dec_req_ready = mst.dec_req_ready;
  assign slv.dec_rsp_valid = mst.dec_rsp_valid;
  assign slv.dec_rsp       = mst.dec_rsp;
  assign mst.dec_rsp_ready = slv.dec_rsp_ready;
  assign slv.exe_rsp_valid = mst.exe_rsp_valid;
  assign slv.exe_rsp       = mst.exe_rsp;
  assign mst.exe_rsp_ready = slv.exe_rsp_ready;

  assign wr_en   = mst.exe_rsp_valid && slv.exe_rsp_ready && mst.exe_rsp.vd_write;
  assign rd_addr = vs_id(req_q.instr, rd_sel);

  xadac_vregfile_mem #(.NoVec(NoVec), .VecBits(VecBits)) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (wr_en),
    .waddr_i (mst.exe_rsp.vd_id),
    .wdata_i (mst.exe_rsp.vd_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    slv.exe_req_ready = 1'b0;
    mst.exe_req_valid = 1'b0;
    rd_en             = 1'b0;
    rd_sel            = '0;
    unique case (state_q)
      IDLE: begin
        slv.exe_req_ready = 1'b1;
        if (slv.exe_req_valid) state_d = RD0;
      end
      RD0: begin
        rd_en   = 1'b1;
        rd_sel  = 2'd0;
        state_d = RD1;
      end
      RD1: begin
        rd_en   = 1'b1;
        rd_sel  = 2'd1;
        state_d = RD2;
      end
      RD2: begin
        rd_en   = 1'b1;
        rd_sel  = 2'd2;
        state_d = SEND;
      end
      SEND: begin
        mst.exe_req_valid = 1'b1;
        if (mst.exe_req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Upstream vs_data is captured only to be overwritten slot by slot during the reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q <= '0;
    end else if (state_q == IDLE && slv.exe_req_valid) begin
      req_q <= slv.exe_req;
    end else if (rd_en) begin
      req_q.vs_data[rd_sel] <= rd_data;
    end
  end

  assign mst.exe_req = req_q;

endmodule

// File: tb/tb_xadac_vregfile.sv
// tb/tb_xadac_vregfile.sv - randomized and directed checks of xadac_vregfile against a register-array model
module tb_xadac_vregfile;
  import xadac_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xadac_if up();
  xadac_if dn();

  xadac_vregfile dut (
    .clk  (clk),
    .rstn (rstn),
    .slv  (up.slv),
    .mst  (dn.mst)
  );

  int tests = 0;
  int fails = 0;
  logic [255:0] model [32];

  task automatic chk(input string tag, input logic [831:0] obs, input logic [831:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [4:0] src(input logic [31:0] ins, input int k);
    if (k == 0) return ins[19:15];
    if (k == 1) return ins[24:20];
    return ins[11:7];
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd);
    logic [31:0] ins;
    ins = $urandom;
    ins[19:15] = vs1;
    ins[24:20] = vs2;
    ins[11:7]  = vd;
    return ins;
  endfunction

  task automatic drive_wr(input logic [4:0] id, input logic [255:0] val);
    dn.exe_rsp_valid        = 1'b1;
    dn.exe_rsp.id           = 4'($urandom);
    dn.exe_rsp.vd_write     = 1'b1;
    dn.exe_rsp.vd_id        = id;
    dn.exe_rsp.vd_data      = val;
    up.exe_rsp_ready        = 1'b1;
    model[id]               = val;
  endtask

  task automatic clr_wr();
    dn.exe_rsp_valid = 1'b0;
    dn.exe_rsp       = '0;
    up.exe_rsp_ready = 1'b0;
  endtask

  // One request through the gather path; optional write in read cycle wr_rel (1..3) and
  // optional writes during bp cycles of downstream backpressure.
  task automatic do_req(input string tag, input logic [31:0] ins, input int wr_rel,
                        input logic [4:0] wr_id, input logic [255:0] wr_val,
                        input int bp, input logic bp_wr);
    logic [255:0] exp [3];
    exe_req_t want;
    up.exe_req_valid        = 1'b1;
    up.exe_req.id           = 4'($urandom);
    up.exe_req.instr        = ins;
    up.exe_req.vs_data      = {rand256(), rand256(), rand256()};
    want                    = '0;
    want.id                 = up.exe_req.id;
    want.instr              = ins;
    dn.exe_req_ready        = 1'b0;
    #2;
    chk({tag, "_accept"}, 832'(up.exe_req_ready), 832'(1'b1));
    step();
    up.exe_req_valid = 1'b0;
    up.exe_req       = '0;
    for (int c = 1; c <= 3; c++) begin
      if (c == wr_rel) drive_wr(wr_id, wr_val);
      exp[c-1] = model[src(ins, c-1)];
      #2;
      chk({tag, "_rd_valid"}, 832'(dn.exe_req_valid), 832'(1'b0));
      chk({tag, "_rd_ready"}, 832'(up.exe_req_ready), 832'(1'b0));
      step();
      clr_wr();
    end
    want.vs_data = {exp[2], exp[1], exp[0]};
    for (int c = 0; c < bp; c++) begin
      if (bp_wr) drive_wr(wr_id, wr_val);
      #2;
      chk({tag, "_bp_valid"}, 832'(dn.exe_req_valid), 832'(1'b1));
      chk({tag, "_bp_data"},  832'(dn.exe_req), 832'(want));
      chk({tag, "_bp_ready"}, 832'(up.exe_req_ready), 832'(1'b0));
      step();
      clr_wr();
    end
    dn.exe_req_ready = 1'b1;
    #2;
    chk({tag, "_send_valid"}, 832'(dn.exe_req_valid), 832'(1'b1));
    chk({tag, "_send_data"},  832'(dn.exe_req), 832'(want));
    step();
    dn.exe_req_ready = 1'b0;
    #2;
    chk({tag, "_idle_valid"}, 832'(dn.exe_req_valid), 832'(1'b0));
    chk({tag, "_idle_ready"}, 832'(up.exe_req_ready), 832'(1'b1));
    step();
  endtask

  task automatic pt_cycle();
    logic dqv, dqr, dsv, dsr, erv, err;
    dec_req_t dq;
    dec_rsp_t ds;
    exe_rsp_t er;
    dqv = 1'($urandom); dqr = 1'($urandom); dsv = 1'($urandom);
    dsr = 1'($urandom); erv = 1'($urandom); err = 1'($urandom);
    dq.id = 4'($urandom); dq.instr = $urandom;
    ds.id = 4'($urandom); ds.vs_read = 3'($urandom); ds.vd_write = 1'($urandom);
    er.id = 4'($urandom); er.vd_write = 1'($urandom); er.vd_id = 5'($urandom); er.vd_data = rand256();
    up.dec_req_valid = dqv; up.dec_req = dq; dn.dec_req_ready = dqr;
    dn.dec_rsp_valid = dsv; dn.dec_rsp = ds; up.dec_rsp_ready = dsr;
    dn.exe_rsp_valid = erv; dn.exe_rsp = er; up.exe_rsp_ready = err;
    #2;
    chk("pt_dec_req_valid", 832'(dn.dec_req_valid), 832'(dqv));
    chk("pt_dec_req",       832'(dn.dec_req),       832'(dq));
    chk("pt_dec_req_ready", 832'(up.dec_req_ready), 832'(dqr));
    chk("pt_dec_rsp_valid", 832'(up.dec_rsp_valid), 832'(dsv));
    chk("pt_dec_rsp",       832'(up.dec_rsp),       832'(ds));
    chk("pt_dec_rsp_ready", 832'(dn.dec_rsp_ready), 832'(dsr));
    chk("pt_exe_rsp_valid", 832'(up.exe_rsp_valid), 832'(erv));
    chk("pt_exe_rsp",       832'(up.exe_rsp),       832'(er));
    chk("pt_exe_rsp_ready", 832'(dn.exe_rsp_ready), 832'(err));
    if (rstn && erv && err && er.vd_write) model[er.vd_id] = er.vd_data;
    step();
  endtask

  initial begin
    int hs [$];
    logic [31:0] ins;
    rstn = 1'b0;
    up.dec_req_valid = 1'b0; up.dec_req = '0; up.dec_rsp_ready = 1'b0;
    up.exe_req_valid = 1'b0; up.exe_req = '0; up.exe_rsp_ready = 1'b0;
    dn.dec_req_ready = 1'b0; dn.dec_rsp_valid = 1'b0; dn.dec_rsp = '0;
    dn.exe_req_ready = 1'b0; dn.exe_rsp_valid = 1'b0; dn.exe_rsp = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    step();
    #2;
    chk("rst_exe_req_valid", 832'(dn.exe_req_valid), 832'(1'b0));
    chk("rst_exe_req_ready", 832'(up.exe_req_ready), 832'(1'b1));
    chk("rst_exe_req_data",  832'(dn.exe_req), 832'(0));
    step();
    for (int i = 0; i < 3; i++) pt_cycle();
    clr_wr();
    rstn = 1'b1;
    step();

    // Write-then-read, then backpressure with a concurrent overwrite of v3.
    drive_wr(5'd3, {32{8'hA5}});
    step();
    clr_wr();
    do_req("wtr", mk_instr(5'd3, 5'd0, 5'd3), 0, 5'd3, {32{8'h11}}, 10, 1'b1);

    // Bypass: v7 written in the cycle it is read as vs2.
    do_req("bypass", mk_instr(5'd12, 5'd7, 5'd7), 2, 5'd7, {32{8'hFF}}, 0, 1'b0);

    // Repeated source id.
    drive_wr(5'd9, rand256());
    step();
    clr_wr();
    do_req("repeat", mk_instr(5'd9, 5'd9, 5'd9), 0, 5'd0, '0, 1, 1'b0);

    // Throughput with upstream valid held high and downstream always ready.
    up.exe_req_valid = 1'b1;
    up.exe_req.instr = $urandom;
    dn.exe_req_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      #2;
      if (up.exe_req_ready) hs.push_back(c);
      step();
    end
    up.exe_req_valid = 1'b0;
    chk("tput_count", 832'(hs.size()), 832'(3));
    chk("tput_hs0", 832'(hs.size() > 0 ? hs[0] : -1), 832'(0));
    chk("tput_hs1", 832'(hs.size() > 1 ? hs[1] : -1), 832'(5));
    chk("tput_hs2", 832'(hs.size() > 2 ? hs[2] : -1), 832'(10));
    for (int c = 0; c < 5; c++) step();
    dn.exe_req_ready = 1'b0;
    #2;
    chk("tput_drained", 832'(up.exe_req_ready), 832'(1'b1));
    step();

    // Pass-through traffic, writes included via the model.
    for (int i = 0; i < 20; i++) pt_cycle();
    clr_wr();
    up.dec_req_valid = 1'b0; dn.dec_rsp_valid = 1'b0;

    // Randomized requests with writes landing before, at or after each read.
    for (int n = 0; n < 10; n++) begin
      ins = mk_instr(5'($urandom), 5'($urandom), 5'($urandom));
      do_req("rand", ins, $urandom_range(0, 3),
             ($urandom_range(0, 1) == 1) ? src(ins, $urandom_range(0, 2)) : 5'($urandom),
             rand256(), $urandom_range(0, 3), 1'($urandom));
    end

    // Reset in RD2 drops the request and clears the array.
    drive_wr(5'd3, rand256());
    step();
    clr_wr();
    up.exe_req_valid = 1'b1;
    up.exe_req.instr = mk_instr(5'd3, 5'd3, 5'd3);
    dn.exe_req_ready = 1'b1;
    #2;
    chk("rst_mid_accept", 832'(up.exe_req_ready), 832'(1'b1));
    step();
    up.exe_req_valid = 1'b0;
    step();
    step();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 832'(dn.exe_req_valid), 832'(1'b0));
    chk("rst_mid_ready", 832'(up.exe_req_ready), 832'(1'b1));
    step();
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("rst_no_pulse", 832'(dn.exe_req_valid), 832'(1'b0));
      step();
    end
    dn.exe_req_ready = 1'b0;
    do_req("post_rst", mk_instr(5'd3, 5'd3, 5'd3), 0, 5'd0, '0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xadac_vregfile.md
XADAC_VREGFILE -- requirements
Module: xadac_vregfile

Interface
- REQ-001: Parameter NoVec, default 32 (package constant), number of vector registers.
- REQ-002: Parameter VecBits, default 256 (package constant), bits per vector register.
- REQ-003: Parameter NoVs, default 3 (package constant), source operands per instruction.
- REQ-004: clk  input  1  clock, all state on rising edge.
- REQ-005: rstn  input  1  reset, asynchronous, active-low.
- REQ-006: slv  xadac_if.slv  -  upstream port, fed by the clobber stage; channels dec_req, dec_rsp, exe_req, exe_rsp.
- REQ-007: mst  xadac_if.mst  -  downstream port to the execution unit; exe_req carries vs_data[NoVs][VecBits]; exe_rsp carries id, vd_write (1), vd_id (RegIdT), vd_data (VecBits).

Function
- REQ-008: dec_req/dec_rsp SHALL pass through combinationally, with valid, ready and payload unchanged.
- REQ-009: exe_rsp valid/ready/payload SHALL pass through combinationally.
- REQ-010: The FSM SHALL have states IDLE, RD0, RD1, RD2, SEND.
- REQ-011: slv.exe_req_ready SHALL be 1 only in IDLE.
- REQ-012: On an IDLE handshake, the block SHALL capture the exe_req payload and source ids vs_id[0]=instr[19:15], vs_id[1]=instr[24:20], vs_id[2]=instr[11:7], then go to RD0.
- REQ-013: In RDi, the block SHALL read register vs_id[i] through the single read port into vs_data[i], advancing RD0->RD1->RD2->SEND one state per cycle.
- REQ-014: In SEND, mst.exe_req_valid SHALL be 1, carrying the captured payload plus vs_data.
- REQ-015: Payload SHALL stay stable until mst.exe_req_ready; the handshake cycle returns to IDLE.
- REQ-016: Minimum latency SHALL be: slv handshake at cycle t, mst.exe_req_valid at t+4; throughput at most one request per 5 cycles.
- REQ-017: mst.exe_req_valid SHALL be 0 in every state except SEND.
- REQ-018: Write port: when mst.exe_rsp_valid && slv.exe_rsp_ready && vd_write, the block SHALL write vrf[vd_id] <= vd_data at the clock edge; no write without the full handshake.
- REQ-019: Same-cycle write and read of the same register in RDi SHALL return the new vd_data (write-through bypass).
- REQ-020: vs_data SHALL be a snapshot: writes after RDi completes SHALL NOT change the captured vs_data[i], including during SEND backpressure.
- REQ-021: A repeated source id (e.g. vs1==vs2) SHALL be read twice and return identical data.
- REQ-022: Register ids SHALL be 5 bits; NoVec SHALL be 32, so no out-of-range handling is required.
- REQ-023: Writes SHALL be accepted in any FSM state and are independent of the read path.

Reset
- REQ-024: Asserting rstn low SHALL immediately force: state IDLE, mst.exe_req_valid 0, slv.exe_req_ready 1, captured buffer and vs_data 0, all vrf entries 0.
- REQ-025: Reset during RDx or SEND SHALL drop the in-flight request with no mst handshake.
- REQ-026: Pass-through outputs SHALL follow their inputs during reset.

Structure
- REQ-027: NoVec, VecBits, NoVs, RegIdT, IdT and the extended exe_req/exe_rsp payload structs SHALL live in xadac_pkg.
- REQ-028: The FSM enum SHALL be local to the module.
- REQ-029: The register array SHALL be the sub-module xadac_vregfile_mem: 1 read port (combinational, with bypass), 1 write port, asynchronous reset to 0.

Verification
- REQ-030: Write-then-read: write v3=0xA5..A5 via exe_rsp, then exe_req with instr fields vs1=3, vs2=0, vd=3 -> mst vs_data = {A5..A5, 0, A5..A5} at t+4.
- REQ-031: Backpressure: hold mst.exe_req_ready=0 for 10 cycles while writing v3=0x11..11 -> vs_data stays A5..A5, valid held high, slv.exe_req_ready stays 0.
- REQ-032: Bypass: in RD1 (vs2=7), write v7=0xFF..FF the same cycle -> vs_data[1]=FF..FF.
- REQ-033: Throughput: back-to-back slv exe_req_valid with mst ready=1 -> slv handshakes at cycles 0, 5, 10.
- REQ-034: Reset mid-op: deassert rstn in RD2 -> no mst.exe_req_valid pulse; after release, v3 reads 0.
- REQ-035: Pass-through: random dec_req/dec_rsp/exe_rsp traffic -> outputs bit-identical to inputs every cycle.
